// File: rtl/node_rr_arbiter.sv
// Round-robin arbiter that shares one ST/RD/RES/IN compute node among NREQ requesters.
// Operands are latched per requester, jobs are serialised onto the node and each result is returned to its owner.
module node_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int TMO  = 15
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         ST,
  input  logic [NREQ*W-1:0]       IN,
  output logic [NREQ-1:0]         RD,
  output logic [NREQ*W-1:0]       RES,
  output logic                    C_ST,
  output logic [W-1:0]            C_IN,
  input  logic                    C_RD,
  input  logic [W-1:0]            C_RES,
  output logic [$clog2(NREQ)-1:0] GNT,
  output logic                    BUSY,
  output logic                    ERR
);

  localparam int GW = $clog2(NREQ);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [NREQ-1:0]     pend_r, pend_nxt_s;
  logic [NREQ-1:0]     rd_r, rd_nxt_s;
  logic [NREQ-1:0]     st_old_r;
  logic [NREQ-1:0]     capture_s;
  logic [NREQ*W-1:0]   op_r, op_nxt_s;
  logic [NREQ*W-1:0]   res_r, res_nxt_s;
  logic                c_st_r, c_st_nxt_s;
  logic [W-1:0]        c_in_r, c_in_nxt_s;
  logic [GW-1:0]       gnt_r, gnt_nxt_s;
  logic [GW-1:0]       ptr_r, ptr_nxt_s;
  logic [GW-1:0]       ptr_inc_s;
  logic [GW-1:0]       sel_s;
  logic [GW-1:0]       scan_s;
  logic                found_s;
  logic [TW-1:0]       tcnt_r, tcnt_nxt_s;
  logic                err_r, err_nxt_s;
  logic                busy_r;

  // Round-robin pick: first pending requester at or after ptr, wrapping at NREQ.
  always_comb begin
    found_s = 1'b0;
    sel_s   = ptr_r;
    scan_s  = ptr_r;
    for (int k = 0; k < NREQ; k++) begin
      scan_s = GW'((int'(ptr_r) + k) % NREQ);
      if (!found_s && pend_r[scan_s]) begin
        found_s = 1'b1;
        sel_s   = scan_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign ptr_inc_s = (gnt_r == GW'(NREQ - 1)) ? {GW{1'b0}} : gnt_r + 1'b1;

  // Request capture plus the job sequencer; a completing requester's own new edge is masked by pend_r.
  always_comb begin
    capture_s   = ST & ~st_old_r & ~pend_r;
    pend_nxt_s  = pend_r | capture_s;
    rd_nxt_s    = rd_r & ~capture_s;
    op_nxt_s    = op_r;
    res_nxt_s   = res_r;
    state_nxt_s = state_r;
    c_st_nxt_s  = c_st_r;
    c_in_nxt_s  = c_in_r;
    gnt_nxt_s   = gnt_r;
    ptr_nxt_s   = ptr_r;
    tcnt_nxt_s  = tcnt_r;
    err_nxt_s   = err_r;
    for (int i = 0; i < NREQ; i++) begin
      if (capture_s[i]) begin
        op_nxt_s[i*W +: W] = IN[i*W +: W];
      end else begin
        op_nxt_s[i*W +: W] = op_r[i*W +: W];
      end
    end
    case (state_r)
      S_IDLE: begin
        if (found_s) begin
          gnt_nxt_s   = sel_s;
          c_in_nxt_s  = op_r[int'(sel_s)*W +: W];
          c_st_nxt_s  = 1'b1;
          tcnt_nxt_s  = {TW{1'b0}};
          state_nxt_s = S_ISSUE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!C_RD) begin
          state_nxt_s = S_WAIT;
          c_st_nxt_s  = 1'b0;
        end else if (tcnt_r == TW'(TMO)) begin
          state_nxt_s       = S_IDLE;
          c_st_nxt_s        = 1'b0;
          err_nxt_s         = 1'b1;
          pend_nxt_s[gnt_r] = 1'b0;
          rd_nxt_s[gnt_r]   = 1'b1;
          ptr_nxt_s         = ptr_inc_s;
        end else begin
          tcnt_nxt_s = tcnt_r + 1'b1;
        end
      end
      S_WAIT: begin
        if (C_RD) begin
          res_nxt_s[int'(gnt_r)*W +: W] = C_RES;
          pend_nxt_s[gnt_r]             = 1'b0;
          rd_nxt_s[gnt_r]               = 1'b1;
          ptr_nxt_s                     = ptr_inc_s;
          state_nxt_s                   = S_IDLE;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        c_st_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; RST abandons any job in flight but still tracks ST history.
  always_ff @(posedge CLK) begin
    st_old_r <= ST;
    if (RST) begin
      state_r <= S_IDLE;
      pend_r  <= {NREQ{1'b0}};
      rd_r    <= {NREQ{1'b1}};
      op_r    <= {(NREQ*W){1'b0}};
      res_r   <= {(NREQ*W){1'b0}};
      c_st_r  <= 1'b0;
      c_in_r  <= {W{1'b0}};
      gnt_r   <= {GW{1'b0}};
      ptr_r   <= {GW{1'b0}};
      tcnt_r  <= {TW{1'b0}};
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pend_r  <= pend_nxt_s;
      rd_r    <= rd_nxt_s;
      op_r    <= op_nxt_s;
      res_r   <= res_nxt_s;
      c_st_r  <= c_st_nxt_s;
      c_in_r  <= c_in_nxt_s;
      gnt_r   <= gnt_nxt_s;
      ptr_r   <= ptr_nxt_s;
      tcnt_r  <= tcnt_nxt_s;
      err_r   <= err_nxt_s;
      busy_r  <= (state_nxt_s != S_IDLE);
    end
  end

  assign RD   = rd_r;
  assign RES  = res_r;
  assign C_ST = c_st_r;
  assign C_IN = c_in_r;
  assign GNT  = gnt_r;
  assign BUSY = busy_r;
  assign ERR  = err_r;

endmodule

// File: tb/tb_node_rr_arbiter.sv
// Bench for node_rr_arbiter: an increment node, a job-level scoreboard checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_node_rr_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int TMO  = 15;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   ST;
  logic [NREQ*W-1:0] IN;
  logic [NREQ-1:0]   RD;
  logic [NREQ*W-1:0] RES;
  logic              C_ST;
  logic [W-1:0]      C_IN;
  logic              C_RD;
  logic [W-1:0]      C_RES;
  logic [1:0]        GNT;
  logic              BUSY;
  logic              ERR;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int stuck_cycles = 0;

  node_rr_arbiter #(.NREQ(NREQ), .W(W), .TMO(TMO)) dut (
    .CLK(CLK), .RST(RST), .ST(ST), .IN(IN), .RD(RD), .RES(RES),
    .C_ST(C_ST), .C_IN(C_IN), .C_RD(C_RD), .C_RES(C_RES),
    .GNT(GNT), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Shared increment node: RD low for two cycles per job; ignores jobs whose operand is ignore_val.
  logic         n_rd  = 1'b1;
  logic [W-1:0] n_res = 16'h0000;
  logic [W-1:0] n_op  = 16'h0000;
  logic         n_old = 1'b0;
  int           n_cnt = 0;
  logic [W-1:0] ignore_val = 16'hBAD1;
  logic [W-1:0] start_log[$];

  assign C_RD  = n_rd;
  assign C_RES = n_res;

  always @(posedge CLK) begin
    n_old <= C_ST;
    if (C_ST && !n_old) start_log.push_back(C_IN);
    if (n_rd) begin
      if (C_ST && !n_old && C_IN != ignore_val) begin
        n_rd  <= 1'b0;
        n_op  <= C_IN;
        n_cnt <= 2;
      end
    end else if (n_cnt == 1) begin
      n_rd  <= 1'b1;
      n_res <= n_op + 16'd1;
    end else begin
      n_cnt <= n_cnt - 1;
    end
  end

  // Job-level scoreboard: pending set, round-robin pick, one job in flight with a start timestamp.
  logic [NREQ-1:0] m_pend;
  logic [NREQ-1:0] m_st_old;
  logic [W-1:0]    m_op  [NREQ];
  logic [W-1:0]    m_res [NREQ];
  logic [W-1:0]    m_cin;
  logic            m_err;
  bit              m_active, m_acc;
  int              m_ptr, m_owner, m_start;
  int              cyc = 0;

  function automatic int rr_pick(input logic [NREQ-1:0] p, input int ptr);
    for (int d = 0; d < NREQ; d++) begin
      if (p[(ptr + d) % NREQ]) return (ptr + d) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge CLK) begin
    cyc      <= cyc + 1;
    m_st_old <= ST;
    if (RST) begin
      m_pend   <= '0;
      m_err    <= 1'b0;
      m_active <= 1'b0;
      m_acc    <= 1'b0;
      m_ptr    <= 0;
      m_owner  <= 0;
      m_start  <= 0;
      m_cin    <= '0;
      for (int i = 0; i < NREQ; i++) m_res[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (ST[i] && !m_st_old[i] && !m_pend[i]) begin
          m_pend[i] <= 1'b1;
          m_op[i]   <= IN[i*W +: W];
        end
      end
      if (!m_active) begin
        if (rr_pick(m_pend, m_ptr) >= 0) begin
          m_active <= 1'b1;
          m_acc    <= 1'b0;
          m_owner  <= rr_pick(m_pend, m_ptr);
          m_cin    <= m_op[rr_pick(m_pend, m_ptr)];
          m_start  <= cyc;
        end
      end else if (!m_acc) begin
        if (!C_RD) begin
          m_acc <= 1'b1;
        end else if (cyc - m_start == TMO + 1) begin
          m_err           <= 1'b1;
          m_pend[m_owner] <= 1'b0;
          m_ptr           <= (m_owner + 1) % NREQ;
          m_active        <= 1'b0;
        end
      end else if (C_RD) begin
        m_res[m_owner]  <= C_RES;
        m_pend[m_owner] <= 1'b0;
        m_ptr           <= (m_owner + 1) % NREQ;
        m_active        <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic [NREQ-1:0]   e_rd;
  logic [NREQ*W-1:0] e_res;
  logic [1:0]        e_gnt;

  // Per-cycle comparison of every output against the scoreboard, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      e_rd  = ~m_pend;
      e_gnt = m_owner[1:0];
      for (int i = 0; i < NREQ; i++) e_res[i*W +: W] = m_res[i];
      chk("cyc_RD",   RD,   e_rd);
      chk("cyc_RES",  RES,  e_res);
      chk("cyc_ERR",  ERR,  m_err);
      chk("cyc_BUSY", BUSY, m_active);
      chk("cyc_GNT",  GNT,  e_gnt);
      chk("cyc_C_ST", C_ST, m_active && !m_acc);
      chk("cyc_C_IN", C_IN, m_cin);
      if (C_ST && C_IN == ignore_val) stuck_cycles++;
    end
  end

  task automatic set_in(input int i, input logic [W-1:0] v);
    IN[i*W +: W] = v;
  endtask

  task automatic wait_rd(input int i, input int budget);
    int c = 0;
    while (RD[i] !== 1'b1 && c < budget) begin
      @(negedge CLK);
      c++;
    end
    chk($sformatf("wait_rd%0d", i), RD[i], 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (!(RD === 4'hF && BUSY === 1'b0) && c < budget) begin
      @(negedge CLK);
      c++;
    end
    chk("wait_idle", {RD, BUSY}, 5'b11110);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    ST  = '0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  int fair_ids[2] = '{0, 3};
  int seq;
  int c;
  int stuck0;
  logic [W-1:0] prev_v, cur_v;

  initial begin
    RST = 1'b1;
    ST  = '0;
    IN  = '0;
    @(posedge CLK);
    @(negedge CLK);
    chk_en = 1'b1;
    chk("rst_RD", RD, 4'hF);
    chk("rst_RES", RES, 64'h0);
    chk("rst_C_ST", C_ST, 1'b0);
    chk("rst_BUSY", BUSY, 1'b0);
    chk("rst_ERR", ERR, 1'b0);
    chk("rst_GNT", GNT, 2'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Single job from requester 2: k+1 start, k+3 into WAIT, k+5 result
    set_in(2, 16'h0041);
    ST[2] = 1'b1;
    @(negedge CLK);
    chk("t1_rd_low", RD[2], 1'b0);
    @(negedge CLK);
    chk("t1_cst_k1", C_ST, 1'b1);
    chk("t1_cin_k1", C_IN, 16'h0041);
    chk("t1_gnt", GNT, 2'd2);
    @(negedge CLK);
    chk("t1_cst_k2", C_ST, 1'b1);
    @(negedge CLK);
    chk("t1_cst_k3", C_ST, 1'b0);
    chk("t1_busy_k3", BUSY, 1'b1);
    @(negedge CLK);
    chk("t1_rd_k4", RD[2], 1'b0);
    @(negedge CLK);
    chk("t1_rd_k5", RD[2], 1'b1);
    chk("t1_res", RES, 64'h0000_0042_0000_0000);
    chk("t1_gnt_hold", GNT, 2'd2);
    ST[2] = 1'b0;

    // Simultaneous requests from a fresh pointer
    do_reset();
    start_log.delete();
    IN = {16'd40, 16'd30, 16'd20, 16'd10};
    ST = 4'hF;
    @(negedge CLK);
    wait_idle(100);
    chk("t2_nstart", start_log.size(), 4);
    chk("t2_ord0", start_log[0], 16'd10);
    chk("t2_ord1", start_log[1], 16'd20);
    chk("t2_ord2", start_log[2], 16'd30);
    chk("t2_ord3", start_log[3], 16'd40);
    chk("t2_res", RES, {16'd41, 16'd31, 16'd21, 16'd11});
    chk("t2_err", ERR, 1'b0);
    ST = '0;
    @(negedge CLK);

    // Fairness: requesters 0 and 3 re-request right after each completion
    start_log.delete();
    seq = 0;
    c = 0;
    while (start_log.size() < 8 && c < 300) begin
      foreach (fair_ids[j]) begin
        if (!ST[fair_ids[j]]) begin
          set_in(fair_ids[j], {(fair_ids[j] == 0) ? 8'h0A : 8'h0D, 8'(seq)});
          ST[fair_ids[j]] = 1'b1;
          seq++;
        end else if (RD[fair_ids[j]]) begin
          ST[fair_ids[j]] = 1'b0;
        end
      end
      @(negedge CLK);
      c++;
    end
    ST = '0;
    chk("t3_enough", start_log.size() >= 8, 1'b1);
    wait_idle(100);
    prev_v = start_log[0];
    chk("t3_first", prev_v[15:8], 8'h0A);
    for (int j = 1; j < 8; j++) begin
      cur_v = start_log[j];
      chk($sformatf("t3_alt%0d", j), cur_v[15:8] != prev_v[15:8], 1'b1);
      prev_v = cur_v;
    end

    // Duplicate rising edge while pending is ignored, operand unchanged
    start_log.delete();
    set_in(1, 16'h0111);
    ST[1] = 1'b1;
    @(negedge CLK);
    ST[1] = 1'b0;
    @(negedge CLK);
    chk("t4_pending", RD[1], 1'b0);
    set_in(1, 16'h0222);
    ST[1] = 1'b1;
    @(negedge CLK);
    wait_rd(1, 50);
    chk("t4_res", RES[31:16], 16'h0112);
    repeat (10) @(negedge CLK);
    chk("t4_njobs", start_log.size(), 1);
    chk("t4_op", start_log[0], 16'h0111);
    ST[1] = 1'b0;
    @(negedge CLK);

    // Timeout on requester 1, then requester 2 served normally
    start_log.delete();
    stuck0 = stuck_cycles;
    set_in(1, 16'hBAD1);
    ST[1] = 1'b1;
    @(negedge CLK);
    set_in(2, 16'h0100);
    ST[2] = 1'b1;
    @(negedge CLK);
    wait_rd(1, 60);
    chk("t5_err", ERR, 1'b1);
    chk("t5_res1_kept", RES[31:16], 16'h0112);
    chk("t5_issue_cycles", stuck_cycles - stuck0, TMO + 1);
    wait_rd(2, 60);
    chk("t5_res2", RES[47:32], 16'h0101);
    chk("t5_err_sticky", ERR, 1'b1);
    chk("t5_log0", start_log[0], 16'hBAD1);
    chk("t5_log1", start_log[1], 16'h0100);
    ST = '0;
    @(negedge CLK);

    // Reset while the job sits in WAIT
    set_in(0, 16'h0500);
    ST[0] = 1'b1;
    @(negedge CLK);
    c = 0;
    while (!(BUSY === 1'b1 && C_ST === 1'b0) && c < 20) begin
      @(negedge CLK);
      c++;
    end
    chk("t6_in_wait", {BUSY, C_ST}, 2'b10);
    chk("t6_err_before", ERR, 1'b1);
    RST = 1'b1;
    ST  = '0;
    @(negedge CLK);
    chk("t6_rd", RD, 4'hF);
    chk("t6_cst", C_ST, 1'b0);
    chk("t6_busy", BUSY, 1'b0);
    chk("t6_res", RES, 64'h0);
    chk("t6_err", ERR, 1'b0);
    RST = 1'b0;
    c = 0;
    while (n_rd !== 1'b1 && c < 20) begin
      @(negedge CLK);
      c++;
    end
    chk("t6_node_ready", n_rd, 1'b1);
    @(negedge CLK);
    set_in(0, 16'h0600);
    ST[0] = 1'b1;
    @(negedge CLK);
    wait_rd(0, 50);
    chk("t6_res_after", RES[15:0], 16'h0601);
    ST = '0;
    repeat (3) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
